id_stage: RTL and testbench

ID_STAGE -- requirements
Module: ID_Stage

---
 rtl/id_stage_pkg.sv | 26 ++
 rtl/id_stage_register_file.sv | 46 ++++
 rtl/id_stage.sv | 93 +++++++++
 tb/tb_id_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared constants for the instruction-decode stage: datapath width,
// register count, register address width and instruction field positions.
package id_stage_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;
  localparam int FUNCT_W = FUNCT_MSB - FUNCT_LSB + 1;

endpackage

// File: rtl/id_stage_register_file.sv
// Architectural register file: two combinational read ports, one write port,
// write-first bypass on both read ports, register 0 hard-wired to zero.
module id_stage_register_file #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_live;

  // A write to register 0 is never live, so it can neither land nor bypass.
  assign wr_live = we && (waddr != '0);

  // Storage update; reset wins over a coincident writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: zero for register 0, same-cycle writeback data on address match.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (wr_live && (waddr == raddr1)) rdata1 = wdata;
    if (wr_live && (waddr == raddr2)) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: field decode, register-file read with writeback
// bypass, and the ID/EX pipeline register with flush/stall control.
module id_stage #(
  parameter int DATA_W = id_stage_pkg::DATA_W,
  parameter int NREG   = id_stage_pkg::NREG
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   IFtoID_Instr,
  input  logic [31:0]                   IFtoID_PCplus4,
  input  logic                          IFtoID_Valid,
  input  logic [DATA_W-1:0]             WB_WriteReg,
  input  logic [id_stage_pkg::REG_AW-1:0] WB_RegDest,
  input  logic                          WB_RegWrite,
  input  logic                          Stall,
  input  logic                          Flush,
  output logic [DATA_W-1:0]             IDtoEX_ReadData1,
  output logic [DATA_W-1:0]             IDtoEX_ReadData2,
  output logic [DATA_W-1:0]             IDtoEX_SignExt,
  output logic [id_stage_pkg::REG_AW-1:0] IDtoEX_Rs,
  output logic [id_stage_pkg::REG_AW-1:0] IDtoEX_Rt,
  output logic [id_stage_pkg::REG_AW-1:0] IDtoEX_Rd,
  output logic [id_stage_pkg::OPC_W-1:0]  IDtoEX_Opcode,
  output logic [id_stage_pkg::FUNCT_W-1:0] IDtoEX_Funct,
  output logic [31:0]                   IDtoEX_PCplus4,
  output logic                          IDtoEX_Valid
);

  import id_stage_pkg::*;

  logic [REG_AW-1:0]  rs;
  logic [REG_AW-1:0]  rt;
  logic [REG_AW-1:0]  rd;
  logic [IMM_W-1:0]   imm;
  logic [OPC_W-1:0]   opcode;
  logic [FUNCT_W-1:0] funct;
  logic [DATA_W-1:0]  sign_ext;
  logic [DATA_W-1:0]  read_data1;
  logic [DATA_W-1:0]  read_data2;

  assign opcode   = IFtoID_Instr[OPC_MSB:OPC_LSB];
  assign rs       = IFtoID_Instr[RS_MSB:RS_LSB];
  assign rt       = IFtoID_Instr[RT_MSB:RT_LSB];
  assign rd       = IFtoID_Instr[RD_MSB:RD_LSB];
  assign imm      = IFtoID_Instr[IMM_MSB:IMM_LSB];
  assign funct    = IFtoID_Instr[FUNCT_MSB:FUNCT_LSB];
  assign sign_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  id_stage_register_file #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (REG_AW)
  ) u_register_file (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (read_data1),
    .rdata2 (read_data2),
    .we     (WB_RegWrite),
    .waddr  (WB_RegDest),
    .wdata  (WB_WriteReg)
  );

  // ID/EX register: reset > flush > stall (hold) > capture. A held entry is
  // deliberately not refreshed by later writebacks; EX forwarding covers that.
  always_ff @(posedge clk) begin
    if (reset || Flush) begin
      IDtoEX_ReadData1 <= '0;
      IDtoEX_ReadData2 <= '0;
      IDtoEX_SignExt   <= '0;
      IDtoEX_Rs        <= '0;
      IDtoEX_Rt        <= '0;
      IDtoEX_Rd        <= '0;
      IDtoEX_Opcode    <= '0;
      IDtoEX_Funct     <= '0;
      IDtoEX_PCplus4   <= '0;
      IDtoEX_Valid     <= 1'b0;
    end else if (!Stall) begin
      IDtoEX_ReadData1 <= read_data1;
      IDtoEX_ReadData2 <= read_data2;
      IDtoEX_SignExt   <= sign_ext;
      IDtoEX_Rs        <= rs;
      IDtoEX_Rt        <= rt;
      IDtoEX_Rd        <= rd;
      IDtoEX_Opcode    <= opcode;
      IDtoEX_Funct     <= funct;
      IDtoEX_PCplus4   <= IFtoID_PCplus4;
      IDtoEX_Valid     <= IFtoID_Valid;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage with hand-computed expectations.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IFtoID_Instr;
  logic [31:0] IFtoID_PCplus4;
  logic        IFtoID_Valid;
  logic [31:0] WB_WriteReg;
  logic [4:0]  WB_RegDest;
  logic        WB_RegWrite;
  logic        Stall;
  logic        Flush;
  logic [31:0] IDtoEX_ReadData1;
  logic [31:0] IDtoEX_ReadData2;
  logic [31:0] IDtoEX_SignExt;
  logic [4:0]  IDtoEX_Rs;
  logic [4:0]  IDtoEX_Rt;
  logic [4:0]  IDtoEX_Rd;
  logic [5:0]  IDtoEX_Opcode;
  logic [5:0]  IDtoEX_Funct;
  logic [31:0] IDtoEX_PCplus4;
  logic        IDtoEX_Valid;

  int checks = 0;
  int errors = 0;

  id_stage dut (
    .clk              (clk),
    .reset            (reset),
    .IFtoID_Instr     (IFtoID_Instr),
    .IFtoID_PCplus4   (IFtoID_PCplus4),
    .IFtoID_Valid     (IFtoID_Valid),
    .WB_WriteReg      (WB_WriteReg),
    .WB_RegDest       (WB_RegDest),
    .WB_RegWrite      (WB_RegWrite),
    .Stall            (Stall),
    .Flush            (Flush),
    .IDtoEX_ReadData1 (IDtoEX_ReadData1),
    .IDtoEX_ReadData2 (IDtoEX_ReadData2),
    .IDtoEX_SignExt   (IDtoEX_SignExt),
    .IDtoEX_Rs        (IDtoEX_Rs),
    .IDtoEX_Rt        (IDtoEX_Rt),
    .IDtoEX_Rd        (IDtoEX_Rd),
    .IDtoEX_Opcode    (IDtoEX_Opcode),
    .IDtoEX_Funct     (IDtoEX_Funct),
    .IDtoEX_PCplus4   (IDtoEX_PCplus4),
    .IDtoEX_Valid     (IDtoEX_Valid)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; IFtoID_Instr = 32'h012A_4020; IFtoID_PCplus4 = 32'h44; IFtoID_Valid = 1'b1;
    WB_WriteReg = '0; WB_RegDest = '0; WB_RegWrite = 1'b0; Stall = 1'b0; Flush = 1'b0;
    tick(); tick();
    checks++; if (IDtoEX_ReadData1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h exp 0", IDtoEX_ReadData1); end
    checks++; if (IDtoEX_ReadData2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got %h exp 0", IDtoEX_ReadData2); end
    checks++; if (IDtoEX_SignExt !== 32'h0) begin errors++; $display("FAIL reset_signext got %h exp 0", IDtoEX_SignExt); end
    checks++; if (IDtoEX_Rs !== 5'd0 || IDtoEX_Rt !== 5'd0 || IDtoEX_Rd !== 5'd0) begin errors++; $display("FAIL reset_regs got %0d/%0d/%0d exp 0/0/0", IDtoEX_Rs, IDtoEX_Rt, IDtoEX_Rd); end
    checks++; if (IDtoEX_Opcode !== 6'd0 || IDtoEX_Funct !== 6'd0) begin errors++; $display("FAIL reset_opfn got %h/%h exp 0/0", IDtoEX_Opcode, IDtoEX_Funct); end
    checks++; if (IDtoEX_PCplus4 !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", IDtoEX_PCplus4); end
    checks++; if (IDtoEX_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", IDtoEX_Valid); end
  endtask

  // add $8,$9,$10 right after reset: operands zero, fields decoded.
  task automatic test_decode_add();
    reset = 1'b0; IFtoID_Instr = 32'h012A_4020; IFtoID_PCplus4 = 32'h104; IFtoID_Valid = 1'b1;
    tick();
    checks++; if (IDtoEX_ReadData1 !== 32'h0) begin errors++; $display("FAIL add_rd1 got %h exp 0", IDtoEX_ReadData1); end
    checks++; if (IDtoEX_ReadData2 !== 32'h0) begin errors++; $display("FAIL add_rd2 got %h exp 0", IDtoEX_ReadData2); end
    checks++; if (IDtoEX_Rs !== 5'd9) begin errors++; $display("FAIL add_rs got %0d exp 9", IDtoEX_Rs); end
    checks++; if (IDtoEX_Rt !== 5'd10) begin errors++; $display("FAIL add_rt got %0d exp 10", IDtoEX_Rt); end
    checks++; if (IDtoEX_Rd !== 5'd8) begin errors++; $display("FAIL add_rd got %0d exp 8", IDtoEX_Rd); end
    checks++; if (IDtoEX_Opcode !== 6'h00) begin errors++; $display("FAIL add_opcode got %h exp 00", IDtoEX_Opcode); end
    checks++; if (IDtoEX_Funct !== 6'h20) begin errors++; $display("FAIL add_funct got %h exp 20", IDtoEX_Funct); end
    checks++; if (IDtoEX_SignExt !== 32'h0000_4020) begin errors++; $display("FAIL add_signext got %h exp 00004020", IDtoEX_SignExt); end
    checks++; if (IDtoEX_PCplus4 !== 32'h104) begin errors++; $display("FAIL add_pc got %h exp 104", IDtoEX_PCplus4); end
    checks++; if (IDtoEX_Valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", IDtoEX_Valid); end
  endtask

  task automatic test_wb_read();
    IFtoID_Instr = 32'h0; WB_RegWrite = 1'b1; WB_RegDest = 5'd9; WB_WriteReg = 32'h1234_5678;
    tick();
    WB_RegWrite = 1'b0; IFtoID_Instr = 32'h012A_4020;
    tick();
    checks++; if (IDtoEX_ReadData1 !== 32'h1234_5678) begin errors++; $display("FAIL wb_read_rd1 got %h exp 12345678", IDtoEX_ReadData1); end
    checks++; if (IDtoEX_ReadData2 !== 32'h0) begin errors++; $display("FAIL wb_read_rd2 got %h exp 0", IDtoEX_ReadData2); end
  endtask

  task automatic test_bypass();
    IFtoID_Instr = 32'h012A_4020; WB_RegWrite = 1'b1; WB_RegDest = 5'd10; WB_WriteReg = 32'hDEAD_BEEF;
    tick();
    WB_RegWrite = 1'b0;
    checks++; if (IDtoEX_ReadData2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rd2 got %h exp deadbeef", IDtoEX_ReadData2); end
    checks++; if (IDtoEX_ReadData1 !== 32'h1234_5678) begin errors++; $display("FAIL bypass_rd1 got %h exp 12345678", IDtoEX_ReadData1); end
  endtask

  // Register 0 ignores writes and bypass; immediate sign extension at both edges.
  task automatic test_x0_signext();
    IFtoID_Instr = 32'h8C09_8000; WB_RegWrite = 1'b1; WB_RegDest = 5'd0; WB_WriteReg = 32'hFFFF_FFFF;
    tick();
    WB_RegWrite = 1'b0;
    checks++; if (IDtoEX_ReadData1 !== 32'h0) begin errors++; $display("FAIL x0_bypass_rd1 got %h exp 0", IDtoEX_ReadData1); end
    checks++; if (IDtoEX_ReadData2 !== 32'h1234_5678) begin errors++; $display("FAIL lw_rd2 got %h exp 12345678", IDtoEX_ReadData2); end
    checks++; if (IDtoEX_SignExt !== 32'hFFFF_8000) begin errors++; $display("FAIL signext_neg got %h exp ffff8000", IDtoEX_SignExt); end
    checks++; if (IDtoEX_Opcode !== 6'h23) begin errors++; $display("FAIL lw_opcode got %h exp 23", IDtoEX_Opcode); end
    IFtoID_Instr = 32'h8C00_7FFF;
    tick();
    checks++; if (IDtoEX_ReadData1 !== 32'h0 || IDtoEX_ReadData2 !== 32'h0) begin errors++; $display("FAIL x0_stored got %h/%h exp 0/0", IDtoEX_ReadData1, IDtoEX_ReadData2); end
    checks++; if (IDtoEX_SignExt !== 32'h0000_7FFF) begin errors++; $display("FAIL signext_pos got %h exp 00007fff", IDtoEX_SignExt); end
  endtask

  // Hold for three cycles while inputs and the register file change; then flush over stall.
  task automatic test_stall_flush();
    IFtoID_Instr = 32'h012A_4020; IFtoID_PCplus4 = 32'h200; IFtoID_Valid = 1'b1;
    tick();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IFtoID_Instr = 32'h8C09_8000 + i; IFtoID_PCplus4 = 32'h300 + 4 * i; IFtoID_Valid = (i != 1);
      WB_RegWrite = (i == 0); WB_RegDest = 5'd9; WB_WriteReg = 32'h55;
      tick();
      checks++; if (IDtoEX_ReadData1 !== 32'h1234_5678 || IDtoEX_ReadData2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_ops[%0d] got %h/%h exp 12345678/deadbeef", i, IDtoEX_ReadData1, IDtoEX_ReadData2); end
      checks++; if (IDtoEX_Rs !== 5'd9 || IDtoEX_Rt !== 5'd10 || IDtoEX_Rd !== 5'd8) begin errors++; $display("FAIL stall_regs[%0d] got %0d/%0d/%0d exp 9/10/8", i, IDtoEX_Rs, IDtoEX_Rt, IDtoEX_Rd); end
      checks++; if (IDtoEX_PCplus4 !== 32'h200 || IDtoEX_SignExt !== 32'h4020 || IDtoEX_Funct !== 6'h20 || IDtoEX_Valid !== 1'b1) begin errors++; $display("FAIL stall_misc[%0d] got %h/%h/%h/%b exp 200/4020/20/1", i, IDtoEX_PCplus4, IDtoEX_SignExt, IDtoEX_Funct, IDtoEX_Valid); end
    end
    WB_RegWrite = 1'b0; Stall = 1'b0; IFtoID_Instr = 32'h012A_4020; IFtoID_PCplus4 = 32'h210; IFtoID_Valid = 1'b1;
    tick();
    checks++; if (IDtoEX_ReadData1 !== 32'h55) begin errors++; $display("FAIL stall_wb_landed got %h exp 55", IDtoEX_ReadData1); end
    checks++; if (IDtoEX_PCplus4 !== 32'h210) begin errors++; $display("FAIL post_stall_pc got %h exp 210", IDtoEX_PCplus4); end
    Stall = 1'b1; Flush = 1'b1;
    tick();
    Stall = 1'b0; Flush = 1'b0;
    checks++; if (IDtoEX_ReadData1 !== 32'h0 || IDtoEX_ReadData2 !== 32'h0 || IDtoEX_SignExt !== 32'h0) begin errors++; $display("FAIL flush_data got %h/%h/%h exp 0/0/0", IDtoEX_ReadData1, IDtoEX_ReadData2, IDtoEX_SignExt); end
    checks++; if (IDtoEX_Rs !== 5'd0 || IDtoEX_Rt !== 5'd0 || IDtoEX_Rd !== 5'd0 || IDtoEX_Opcode !== 6'd0 || IDtoEX_Funct !== 6'd0) begin errors++; $display("FAIL flush_fields got %0d/%0d/%0d/%h/%h exp all 0", IDtoEX_Rs, IDtoEX_Rt, IDtoEX_Rd, IDtoEX_Opcode, IDtoEX_Funct); end
    checks++; if (IDtoEX_PCplus4 !== 32'h0 || IDtoEX_Valid !== 1'b0) begin errors++; $display("FAIL flush_pc_valid got %h/%b exp 0/0", IDtoEX_PCplus4, IDtoEX_Valid); end
  endtask

  task automatic test_invalid_capture();
    IFtoID_Instr = 32'h012A_4020; IFtoID_PCplus4 = 32'h220; IFtoID_Valid = 1'b0;
    tick();
    checks++; if (IDtoEX_Valid !== 1'b0) begin errors++; $display("FAIL invalid_valid got %b exp 0", IDtoEX_Valid); end
    checks++; if (IDtoEX_Rs !== 5'd9 || IDtoEX_PCplus4 !== 32'h220) begin errors++; $display("FAIL invalid_data got %0d/%h exp 9/220", IDtoEX_Rs, IDtoEX_PCplus4); end
    IFtoID_Valid = 1'b1;
  endtask

  // A writeback coinciding with reset is dropped and reset clears earlier contents.
  task automatic test_reset_wb();
    IFtoID_Instr = 32'h0; WB_RegWrite = 1'b1; WB_RegDest = 5'd5; WB_WriteReg = 32'h11;
    tick();
    reset = 1'b1; WB_WriteReg = 32'hA5A5_A5A5;
    tick();
    reset = 1'b0; WB_RegWrite = 1'b0; IFtoID_Instr = 32'h00A9_0020; IFtoID_PCplus4 = 32'h300;
    tick();
    checks++; if (IDtoEX_ReadData1 !== 32'h0) begin errors++; $display("FAIL reset_wb_r5 got %h exp 0", IDtoEX_ReadData1); end
    checks++; if (IDtoEX_ReadData2 !== 32'h0) begin errors++; $display("FAIL reset_clear_r9 got %h exp 0", IDtoEX_ReadData2); end
    checks++; if (IDtoEX_Rs !== 5'd5 || IDtoEX_Valid !== 1'b1) begin errors++; $display("FAIL reset_wb_capture got %0d/%b exp 5/1", IDtoEX_Rs, IDtoEX_Valid); end
  endtask

  task automatic test_reset_mid_stall();
    IFtoID_Instr = 32'h012A_4020; IFtoID_PCplus4 = 32'h3F0;
    tick();
    Stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (IDtoEX_Rs !== 5'd0 || IDtoEX_PCplus4 !== 32'h0 || IDtoEX_Valid !== 1'b0) begin errors++; $display("FAIL reset_in_stall got %0d/%h/%b exp 0/0/0", IDtoEX_Rs, IDtoEX_PCplus4, IDtoEX_Valid); end
    reset = 1'b0; Stall = 1'b0; IFtoID_Instr = 32'h00A9_0020; IFtoID_PCplus4 = 32'h400;
    tick();
    checks++; if (IDtoEX_Rs !== 5'd5 || IDtoEX_Rt !== 5'd9 || IDtoEX_PCplus4 !== 32'h400 || IDtoEX_Valid !== 1'b1) begin errors++; $display("FAIL after_reset_capture got %0d/%0d/%h/%b exp 5/9/400/1", IDtoEX_Rs, IDtoEX_Rt, IDtoEX_PCplus4, IDtoEX_Valid); end
  endtask

  initial begin
    test_reset();
    test_decode_add();
    test_wb_read();
    test_bypass();
    test_x0_signext();
    test_stall_flush();
    test_invalid_capture();
    test_reset_wb();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
